// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter state encoding used across the controller.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PREC  = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

  localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command scheduler: grants init/refresh/write/read one at a time and muxes
// the grantee onto the pins, with NOP between grants and a per-grant watchdog.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BA_W      = 2,
  parameter int DQ_W      = 16,
  parameter int GRANT_TMO = 1000
) (
  input  logic              sclk,
  input  logic              srst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [DQ_W-1:0]   wr_dq,
  input  logic              wr_dq_oe,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   rd_ba,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              aref_pend,
  output logic              sdram_cke,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [DQ_W-1:0]   sdram_dq_o,
  output logic              sdram_dq_oe,
  output logic              grant_tmo
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(GRANT_TMO - 1);

  arb_state_e           state_q, state_d;
  logic                 rr_last_rd_q, rr_last_rd_d;  // 1: READ was granted last
  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 grant_tmo_q, grant_tmo_d;
  logic                 cke_q;
  logic                 end_seen;

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state_q      <= ST_INIT;
      rr_last_rd_q <= 1'b1;
      tmo_cnt_q    <= '0;
      grant_tmo_q  <= 1'b0;
      cke_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_rd_q <= rr_last_rd_d;
      tmo_cnt_q    <= tmo_cnt_d;
      grant_tmo_q  <= grant_tmo_d;
      cke_q        <= 1'b1;
    end
  end

  // Only the current grantee's end flag is looked at.
  always_comb begin
    end_seen = 1'b0;
    case (state_q)
      ST_AREF:  end_seen = aref_end;
      ST_WRITE: end_seen = wr_end;
      ST_READ:  end_seen = rd_end;
      default:  end_seen = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rr_last_rd_d = rr_last_rd_q;
    tmo_cnt_d    = '0;
    grant_tmo_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req)                 state_d = ST_AREF;
        else if (wr_req && rd_req)    state_d = rr_last_rd_q ? ST_WRITE : ST_READ;
        else if (wr_req)              state_d = ST_WRITE;
        else if (rd_req)              state_d = ST_READ;
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        if (end_seen) begin
          state_d = ST_ARBIT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // Watchdog release; the pulse lands in the following ARBIT cycle.
          state_d     = ST_ARBIT;
          grant_tmo_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (state_d == ST_ARBIT) begin
          if (state_q == ST_WRITE) rr_last_rd_d = 1'b0;
          if (state_q == ST_READ)  rr_last_rd_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign aref_en   = (state_q == ST_AREF);
  assign wr_en     = (state_q == ST_WRITE);
  assign rd_en     = (state_q == ST_READ);
  assign aref_pend = aref_req & (wr_en | rd_en);
  assign sdram_cke = cke_q;
  assign grant_tmo = grant_tmo_q;

  always_comb begin
    sdram_cmd   = CMD_NOP;
    sdram_addr  = '0;
    sdram_ba    = '0;
    sdram_dq_o  = '0;
    sdram_dq_oe = 1'b0;
    case (state_q)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd   = wr_cmd;
        sdram_addr  = wr_addr;
        sdram_ba    = wr_ba;
        sdram_dq_o  = wr_dq;
        sdram_dq_oe = wr_dq_oe;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized bench for sdram_arbit against a grant-level reference model,
// plus directed init, refresh-preemption, watchdog and async-reset scenarios.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int T = 16;
  localparam int M_INIT = 0, M_ARB = 1, M_AREF = 2, M_WR = 3, M_RD = 4;

  logic        sclk, srst_n;
  logic        init_end, aref_req, aref_end, wr_req, wr_end, wr_dq_oe, rd_req, rd_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic [1:0]  wr_ba, rd_ba;
  logic [15:0] wr_dq;
  logic        aref_en, wr_en, rd_en, aref_pend, sdram_cke, sdram_dq_oe, grant_tmo;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [15:0] sdram_dq_o;

  sdram_arbit #(.ADDR_W(12), .BA_W(2), .DQ_W(16), .GRANT_TMO(T)) dut (
    .sclk(sclk), .srst_n(srst_n),
    .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
    .wr_dq(wr_dq), .wr_dq_oe(wr_dq_oe),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
    .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .aref_pend(aref_pend),
    .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_ba(sdram_ba), .sdram_dq_o(sdram_dq_o), .sdram_dq_oe(sdram_dq_oe),
    .grant_tmo(grant_tmo)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int m_st, m_age, n_vec, n_err;
  bit m_last_rd, m_cke, m_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_INIT; m_last_rd = 1'b1; m_age = 0; m_cke = 1'b0; m_tmo = 1'b0;
  endtask

  // Advance the reference by one clock edge using the inputs present at that edge.
  task automatic model_update();
    bit done;
    if (!srst_n) begin
      model_reset();
      return;
    end
    m_cke = 1'b1;
    m_tmo = 1'b0;
    case (m_st)
      M_INIT: if (init_end) m_st = M_ARB;
      M_ARB: begin
        m_age = 0;
        if (aref_req)              m_st = M_AREF;
        else if (wr_req && rd_req) m_st = m_last_rd ? M_WR : M_RD;
        else if (wr_req)           m_st = M_WR;
        else if (rd_req)           m_st = M_RD;
      end
      default: begin
        done = (m_st == M_AREF) ? aref_end : (m_st == M_WR) ? wr_end : rd_end;
        m_age++;
        if (done || m_age == T) begin
          m_tmo = !done;
          $display("grant %0d released after %0d cycles watchdog=%0d", m_st, m_age, m_tmo);
          if (m_st == M_WR) m_last_rd = 1'b0;
          if (m_st == M_RD) m_last_rd = 1'b1;
          m_st = M_ARB;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    logic [3:0]  ecmd;
    logic [11:0] eaddr;
    logic [1:0]  eba;
    ecmd = CMD_NOP; eaddr = '0; eba = '0;
    case (m_st)
      M_INIT: begin ecmd = init_cmd; eaddr = init_addr; end
      M_AREF: begin ecmd = aref_cmd; eaddr = aref_addr; end
      M_WR:   begin ecmd = wr_cmd;   eaddr = wr_addr; eba = wr_ba; end
      M_RD:   begin ecmd = rd_cmd;   eaddr = rd_addr; eba = rd_ba; end
      default: ;
    endcase
    chk("cmd",  32'(sdram_cmd),  32'(ecmd));
    chk("addr", 32'(sdram_addr), 32'(eaddr));
    chk("ba",   32'(sdram_ba),   32'(eba));
    chk("dq",   32'(sdram_dq_o), (m_st == M_WR) ? 32'(wr_dq) : 32'd0);
    chk("oe",   32'(sdram_dq_oe), (m_st == M_WR) ? 32'(wr_dq_oe) : 32'd0);
    chk("aref_en", 32'(aref_en), 32'(m_st == M_AREF));
    chk("wr_en",   32'(wr_en),   32'(m_st == M_WR));
    chk("rd_en",   32'(rd_en),   32'(m_st == M_RD));
    chk("aref_pend", 32'(aref_pend), 32'(aref_req && (m_st == M_WR || m_st == M_RD)));
    chk("cke",  32'(sdram_cke),  32'(m_cke));
    chk("grant_tmo", 32'(grant_tmo), 32'(m_tmo));
  endtask

  // Inputs are driven at edge+2, checked at edge+4, model advanced at edge+1.
  task automatic step();
    #2;
    compare_all();
    @(posedge sclk);
    #1;
    model_update();
    #1;
  endtask

  task automatic rand_data();
    init_cmd = 4'($urandom); aref_cmd = 4'($urandom); wr_cmd = 4'($urandom); rd_cmd = 4'($urandom);
    init_addr = 12'($urandom); aref_addr = 12'($urandom);
    wr_addr = 12'($urandom); rd_addr = 12'($urandom);
    wr_ba = 2'($urandom); rd_ba = 2'($urandom);
    wr_dq = 16'($urandom); wr_dq_oe = 1'($urandom);
  endtask

  task automatic rand_ctrl();
    init_end = ($urandom_range(0, 7) == 0);
    aref_req = ($urandom_range(0, 11) == 0);
    wr_req   = 1'($urandom);
    rd_req   = 1'($urandom);
    aref_end = ($urandom_range(0, 9) == 0);
    wr_end   = ($urandom_range(0, 9) == 0);
    rd_end   = ($urandom_range(0, 9) == 0);
  endtask

  task automatic idle_ctrl();
    init_end = 0; aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
  endtask

  task automatic wait_state(input int target, input int budget);
    int n;
    n = 0;
    while (m_st != target && n < budget) begin
      step();
      n++;
    end
    if (m_st != target) chk("wait_state", 32'(m_st), 32'(target));
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    srst_n = 1'b0;
    idle_ctrl();
    rand_data();
    model_reset();
    repeat (3) step();

    // Power-up: init_end pulse on the 20th cycle after release.
    srst_n = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      rand_data();
      init_end = (c == 20);
      step();
    end

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_data();
      rand_ctrl();
      step();
    end

    // Refresh raised during a write burst preempts the pending read.
    idle_ctrl();
    wr_req = 1; rd_req = 1;
    wait_state(M_WR, 80);
    wr_dq = 16'hA5A5; wr_dq_oe = 1'b1;
    repeat (3) step();
    aref_req = 1;
    repeat (2) step();
    wr_end = 1; wr_req = 0;
    step();
    wr_end = 0;
    step();
    chk("aref_before_rd", 32'(aref_en), 32'd1);
    repeat (4) step();
    aref_end = 1; aref_req = 0;
    step();
    aref_end = 0;
    repeat (3) step();

    // Watchdog release of a read that never ends, then a read ended on its last cycle.
    idle_ctrl();
    rd_req = 1;
    wait_state(M_RD, 80);
    wr_req = 1;
    repeat (T + 3) step();
    wr_end = 1;
    wait_state(M_RD, 80);
    wr_end = 0;
    for (int i = 0; i < T + 2; i++) begin
      rd_end = (m_st == M_RD && m_age == T - 1);
      step();
    end
    rd_end = 0;

    // Asynchronous reset in the middle of a write grant.
    idle_ctrl();
    wr_req = 1; wr_dq_oe = 1'b1;
    wait_state(M_WR, 80);
    step();
    srst_n = 1'b0;
    #1;
    chk("async_wr_en", 32'(wr_en), 32'd0);
    chk("async_oe",    32'(sdram_dq_oe), 32'd0);
    chk("async_cke",   32'(sdram_cke), 32'd0);
    chk("async_cmd",   32'(sdram_cmd), 32'(init_cmd));
    #1;
    model_reset();
    repeat (2) step();
    srst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rand_data();
      rand_ctrl();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
